// File: rtl/adsr_pkg.sv
// Shared types and defaults for the ADSR amplitude-envelope stage.
package adsr_pkg;

    localparam int DWIDTH_DEF = 24;
    localparam int EWIDTH_DEF = 24;

    localparam logic [EWIDTH_DEF-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/Axis_If.sv
// Minimal AXI-stream bundle: data moves on a cycle where valid && ready.
interface Axis_If #(
    parameter int DWIDTH = 24
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              ready;

    modport Master (output data, output valid, input ready);
    modport Slave  (input data, input valid, output ready);
endinterface

// File: rtl/adsr_step.sv
// One envelope update: next state and level from the current state, level, gate and controls.
module adsr_step
    import adsr_pkg::*;
#(
    parameter int EWIDTH = EWIDTH_DEF
) (
    input  env_state_t        state,
    input  logic [EWIDTH-1:0] env,
    input  logic              gate,
    input  logic [EWIDTH-1:0] attack_rate,
    input  logic [EWIDTH-1:0] decay_rate,
    input  logic [EWIDTH-1:0] sustain_level,
    input  logic [EWIDTH-1:0] release_rate,
    output env_state_t        next_state,
    output logic [EWIDTH-1:0] next_env
);

    localparam logic [EWIDTH-1:0] EMAX = '1;

    logic [EWIDTH:0] decay_diff;
    logic            attack_hit;
    logic            decay_hit;
    logic            release_hit;

    // The extra MSB is the borrow; an underflowing decay always lands on sustain.
    assign decay_diff  = {1'b0, env} - {1'b0, decay_rate};
    assign attack_hit  = env >= (EMAX - attack_rate);
    assign decay_hit   = decay_diff[EWIDTH] || (decay_diff[EWIDTH-1:0] <= sustain_level);
    assign release_hit = env <= release_rate;

    always_comb begin
        next_state = state;
        next_env   = env;
        case (state)
            IDLE: begin
                if (gate) next_state = ATTACK;
                else      next_env   = '0;
            end
            ATTACK: begin
                if (!gate) begin
                    next_state = RELEASE;
                end else if (attack_hit) begin
                    next_state = DECAY;
                    next_env   = EMAX;
                end else begin
                    next_env = env + attack_rate;
                end
            end
            DECAY: begin
                if (!gate) begin
                    next_state = RELEASE;
                end else if (decay_hit) begin
                    next_state = SUSTAIN;
                    next_env   = sustain_level;
                end else begin
                    next_env = decay_diff[EWIDTH-1:0];
                end
            end
            SUSTAIN: begin
                if (!gate) next_state = RELEASE;
                else       next_env   = sustain_level;
            end
            RELEASE: begin
                if (gate) begin
                    next_state = ATTACK;
                end else if (release_hit) begin
                    next_state = IDLE;
                    next_env   = '0;
                end else begin
                    next_env = env - release_rate;
                end
            end
            default: begin
                next_state = IDLE;
                next_env   = '0;
            end
        endcase
    end

endmodule

// File: rtl/adsr_envelope.sv
// Multiplies each accepted sample by the ADSR envelope, two-stage pipeline with AXIS backpressure.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int EWIDTH = EWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gate,
    input  logic [EWIDTH-1:0] attack_rate,
    input  logic [EWIDTH-1:0] decay_rate,
    input  logic [EWIDTH-1:0] sustain_level,
    input  logic [EWIDTH-1:0] release_rate,
    Axis_If.Slave             signal_in,
    Axis_If.Master            signal_out,
    output logic [2:0]        env_state
);

    localparam int PW = DWIDTH + EWIDTH + 1;

    // Handshake convention on both streams: a sample moves on a rising edge where
    // valid && ready; a master never drops valid or changes data while waiting for ready.

    env_state_t        state_q;
    env_state_t        next_state;
    logic [EWIDTH-1:0] env_q;
    logic [EWIDTH-1:0] next_env;

    logic              v1;
    logic              v2;
    logic [DWIDTH-1:0] prod_q;
    logic [DWIDTH-1:0] data_q;
    logic              enable;
    logic              in_ready;
    logic              step;

    logic signed [PW-1:0] sample_ext;
    logic signed [PW-1:0] env_ext;
    logic signed [PW-1:0] product;
    logic                 unused_bits;

    assign enable   = !v2 || signal_out.ready;
    assign in_ready = enable && reset;
    assign step     = signal_in.valid && in_ready;

    assign signal_in.ready  = in_ready;
    assign signal_out.valid = v2;
    assign signal_out.data  = data_q;
    assign env_state        = state_q;

    adsr_step #(
        .EWIDTH(EWIDTH)
    ) u_step (
        .state        (state_q),
        .env          (env_q),
        .gate         (gate),
        .attack_rate  (attack_rate),
        .decay_rate   (decay_rate),
        .sustain_level(sustain_level),
        .release_rate (release_rate),
        .next_state   (next_state),
        .next_env     (next_env)
    );

    // Envelope is a non-negative 0.EWIDTH fraction, so it enters the signed multiply zero-extended.
    assign sample_ext  = {{(EWIDTH + 1){signal_in.data[DWIDTH-1]}}, signal_in.data};
    assign env_ext     = {{DWIDTH{1'b0}}, 1'b0, env_q};
    assign product     = sample_ext * env_ext;
    assign unused_bits = ^{product[PW-1], product[EWIDTH-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            env_q   <= '0;
        end else if (step) begin
            state_q <= next_state;
            env_q   <= next_env;
        end
    end

    // Both stages advance together; a stalled S2 freezes S1 and the input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            prod_q <= '0;
            data_q <= '0;
        end else if (enable) begin
            v1 <= step;
            v2 <= v1;
            if (step) prod_q <= product[DWIDTH+EWIDTH-1:EWIDTH];
            if (v1)   data_q <= prod_q;
        end
    end

endmodule
